lsu_ctrl: RTL and testbench

Load/store control stage directly upstream of the memory access block, between EXU and the data memory bus.
- Accepts one memory op per transaction from EXU over a valid/ready handshake.
- Checks alignment, drives a word-aligned bus request with byte strobes, and waits a variable number of cycles for the response.
- Aligns and sign/zero-extends load data and returns the result to WBU over a valid/ready handshake.

---
 rtl/lsu_ctrl_pkg.sv | 53 +++++
 rtl/lsu_ctrl_if.sv | 56 +++++
 rtl/lsu_ctrl_load_align.sv | 42 ++++
 rtl/lsu_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_pkg                                                      |
// | Description : Shared types and helpers for the load/store control stage:   |
// |               access-size encoding (matches the memory stage), FSM states, |
// |               store strobe generation and store lane replication.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package lsu_pkg;

  // Access size, same encoding as the memory stage uses on its size field.
  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_B    = 2'b01,
    SZ_H    = 2'b10,
    SZ_W    = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Byte strobes for a store of the given size at the given low address bits.
  // Loads (size NONE) produce no strobes.
  function automatic logic [3:0] wstrb_gen(input size_e size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      SZ_B:    strb = 4'b0001 << addr_lo;
      SZ_H:    strb = 4'b0011 << {addr_lo[1], 1'b0};
      SZ_W:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Replicate right-justified store data across every lane it may land in,
  // so the strobes alone pick the destination bytes.
  function automatic logic [31:0] wdata_rep(input size_e size, input logic [31:0] data);
    logic [31:0] rep;
    case (size)
      SZ_B:    rep = {4{data[7:0]}};
      SZ_H:    rep = {2{data[15:0]}};
      SZ_W:    rep = data;
      default: rep = 32'h0000_0000;
    endcase
    return rep;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_ctrl_if                                                  |
// | Description : EXU op, data-memory bus and WBU result signals of the LSU.   |
// |               slave  = the LSU control stage itself,                       |
// |               master = its environment (EXU, memory, WBU).                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // EXU -> LSU op
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_wen;
  logic [1:0]        in_ren;
  logic              in_unsigned;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  // LSU -> memory request
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [1:0]        mem_req_size;
  logic [3:0]        mem_req_wstrb;
  logic [DATA_W-1:0] mem_req_wdata;
  // memory -> LSU response
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;
  // LSU -> WBU result
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rdata;
  logic              out_err;

  modport slave (
    input  in_valid, in_wen, in_ren, in_unsigned, in_addr, in_wdata,
    output in_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_size, mem_req_wstrb, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output out_valid, out_rdata, out_err,
    input  out_ready
  );

  modport master (
    output in_valid, in_wen, in_ren, in_unsigned, in_addr, in_wdata,
    input  in_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_size, mem_req_wstrb, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  out_valid, out_rdata, out_err,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_load_align                                               |
// | Description : Picks the addressed byte/half out of a raw aligned word and  |
// |               sign- or zero-extends it. Purely combinational.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lsu_load_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select followed by extension to the full word
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    data   = 32'h0000_0000;
    case (addr_lo)
      2'd0:    w_byte = raw[7:0];
      2'd1:    w_byte = raw[15:8];
      2'd2:    w_byte = raw[23:16];
      default: w_byte = raw[31:24];
    endcase
    w_half = addr_lo[1] ? raw[31:16] : raw[15:0];
    case (size)
      SZ_B:    data = {{24{~is_unsigned & w_byte[7]}}, w_byte};
      SZ_H:    data = {{16{~is_unsigned & w_half[15]}}, w_half};
      SZ_W:    data = raw;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_ctrl                                                     |
// | Description : Load/store control stage between EXU and the data memory     |
// |               bus. Checks alignment, issues one word-aligned request with  |
// |               byte strobes, waits for the response and returns extended    |
// |               load data (or a store completion) to WBU.                    |
// |               Optional macro LSU_TIMEOUT_EN adds a bus watchdog that ends  |
// |               the transaction with an error after TIMEOUT_CYCLES.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire          clk,
  input  wire          rst,     // asynchronous, active-low
  lsu_ctrl_if.slave    bus
);

  state_e              r_state;
  size_e               r_ren;
  logic                r_uns;
  logic [1:0]          r_addr_lo;
  logic                r_in_ready;
  logic                r_req_valid;
  logic                r_req_we;
  logic [ADDR_W-1:0]   r_req_addr;
  size_e               r_req_size;
  logic [3:0]          r_req_wstrb;
  logic [DATA_W-1:0]   r_req_wdata;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_rdata;
  logic                r_out_err;

  size_e               w_in_wen;
  size_e               w_in_ren;
  size_e               w_in_size;
  logic                w_illegal;
  logic                w_misalign;
  logic [DATA_W-1:0]   w_ld_data;
  logic                w_tmo;

  assign w_in_wen   = size_e'(bus.in_wen);
  assign w_in_ren   = size_e'(bus.in_ren);
  // Only one of the enables is non-zero for a legal op, so OR gives its size.
  assign w_in_size  = size_e'(bus.in_wen | bus.in_ren);
  assign w_illegal  = (w_in_wen != SZ_NONE) && (w_in_ren != SZ_NONE);
  assign w_misalign = ((w_in_size == SZ_H) && bus.in_addr[0]) ||
                      ((w_in_size == SZ_W) && (bus.in_addr[1:0] != 2'b00));

  lsu_load_align u_align (
    .size        (r_ren),
    .addr_lo     (r_addr_lo),
    .is_unsigned (r_uns),
    .raw         (bus.mem_rsp_rdata),
    .data        (w_ld_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int c_TCNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [c_TCNT_W-1:0] r_tcnt;

  // Watchdog: counts cycles spent in REQ/WAIT, zero everywhere else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_tcnt <= '0;
    else if ((r_state == ST_REQ) || (r_state == ST_WAIT))
      r_tcnt <= r_tcnt + 1'b1;
    else
      r_tcnt <= '0;
  end

  // Fires on the last bus cycle so DONE is entered exactly TIMEOUT_CYCLES after REQ
  assign w_tmo = ((r_state == ST_REQ) || (r_state == ST_WAIT)) &&
                 (r_tcnt == c_TCNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_tmo        = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ren       <= SZ_NONE;
      r_uns       <= 1'b0;
      r_addr_lo   <= 2'b00;
      r_in_ready  <= 1'b1;
      r_req_valid <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_size  <= SZ_NONE;
      r_req_wstrb <= 4'b0000;
      r_req_wdata <= '0;
      r_out_valid <= 1'b0;
      r_out_rdata <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_ren      <= w_in_ren;
            r_uns      <= bus.in_unsigned;
            r_addr_lo  <= bus.in_addr[1:0];
            r_in_ready <= 1'b0;
            if (w_illegal || w_misalign) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_out_err   <= 1'b1;
              r_out_rdata <= '0;
            end else if (w_in_size == SZ_NONE) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_out_err   <= 1'b0;
              r_out_rdata <= '0;
            end else begin
              r_state     <= ST_REQ;
              r_req_valid <= 1'b1;
              r_req_we    <= (w_in_wen != SZ_NONE);
              r_req_addr  <= {bus.in_addr[ADDR_W-1:2], 2'b00};
              r_req_size  <= w_in_size;
              r_req_wstrb <= wstrb_gen(w_in_wen, bus.in_addr[1:0]);
              r_req_wdata <= wdata_rep(w_in_wen, bus.in_wdata);
            end
          end
        end
        ST_REQ: begin
          if (w_tmo) begin
            r_state     <= ST_DONE;
            r_req_valid <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b1;
            r_out_rdata <= '0;
          end else if (bus.mem_req_ready) begin
            r_state     <= ST_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (w_tmo) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b1;
            r_out_rdata <= '0;
          end else if (bus.mem_rsp_valid) begin
            // Stores latch r_ren = NONE, so the aligner already yields zero.
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b0;
            r_out_rdata <= w_ld_data;
          end
        end
        default: begin
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_rdata <= '0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.mem_req_valid = r_req_valid;
  assign bus.mem_req_we    = r_req_we;
  assign bus.mem_req_addr  = r_req_addr;
  assign bus.mem_req_size  = r_req_size;
  assign bus.mem_req_wstrb = r_req_wstrb;
  assign bus.mem_req_wdata = r_req_wdata;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_rdata     = r_out_rdata;
  assign bus.out_err       = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lsu_ctrl                                                  |
// | Description : Directed self-checking bench for lsu_ctrl. Inputs change and |
// |               outputs are sampled on the falling clock edge.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_req_hs = 0;
  int   n_out_hs = 0;

  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Handshake counters on both sides of the LSU
  always @(posedge clk) begin
    if (bus.mem_req_valid && bus.mem_req_ready) n_req_hs <= n_req_hs + 1;
    if (bus.out_valid && bus.out_ready)         n_out_hs <= n_out_hs + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one op for a single cycle; returns on the falling edge after the accept edge.
  task automatic accept(input logic [1:0] wen, input logic [1:0] ren, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid    = 1'b1;
    bus.in_wen      = wen;
    bus.in_ren      = ren;
    bus.in_unsigned = uns;
    bus.in_addr     = addr;
    bus.in_wdata    = wdata;
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.in_wen      = 2'b00;
    bus.in_ren      = 2'b00;
    bus.in_unsigned = 1'b0;
    bus.in_addr     = 32'h0;
    bus.in_wdata    = 32'h0;
  endtask

  // Full legal op with a zero-wait bus: check request, respond, check result.
  task automatic run_op(input string tag, input logic [1:0] wen, input logic [1:0] ren,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rsp, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    accept(wen, ren, uns, addr, wdata);
    check_eq({tag, "_req_valid"}, {31'd0, bus.mem_req_valid}, 32'd1);
    check_eq({tag, "_req_we"},    {31'd0, bus.mem_req_we}, {31'd0, (wen != 2'b00)});
    check_eq({tag, "_req_addr"},  bus.mem_req_addr, {addr[31:2], 2'b00});
    check_eq({tag, "_req_size"},  {30'd0, bus.mem_req_size}, {30'd0, wen | ren});
    check_eq({tag, "_req_wstrb"}, {28'd0, bus.mem_req_wstrb}, {28'd0, exp_strb});
    check_eq({tag, "_req_wdata"}, bus.mem_req_wdata, exp_wdata);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check_eq({tag, "_req_dropped"}, {31'd0, bus.mem_req_valid}, 32'd0);
    check_eq({tag, "_no_early_out"}, {31'd0, bus.out_valid}, 32'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = rsp;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = 32'h0;
    check_eq({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check_eq({tag, "_out_rdata"}, bus.out_rdata, exp_rdata);
    check_eq({tag, "_out_err"},   {31'd0, bus.out_err}, 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq({tag, "_idle_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check_eq({tag, "_idle_in_ready"},  {31'd0, bus.in_ready}, 32'd1);
  endtask

  // Op that must complete without touching the bus.
  task automatic run_nobus(input string tag, input logic [1:0] wen, input logic [1:0] ren,
                           input logic [31:0] addr, input logic exp_err);
    accept(wen, ren, 1'b0, addr, 32'hFFFF_FFFF);
    check_eq({tag, "_req_valid"}, {31'd0, bus.mem_req_valid}, 32'd0);
    check_eq({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check_eq({tag, "_out_err"},   {31'd0, bus.out_err}, {31'd0, exp_err});
    check_eq({tag, "_out_rdata"}, bus.out_rdata, 32'h0);
    check_eq({tag, "_in_ready"},  {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq({tag, "_idle_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int base_req;
    int base_out;
    bus.in_valid      = 1'b0;
    bus.in_wen        = 2'b00;
    bus.in_ren        = 2'b00;
    bus.in_unsigned   = 1'b0;
    bus.in_addr       = 32'h0;
    bus.in_wdata      = 32'h0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = 32'h0;
    bus.out_ready     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    check_eq("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_out_rdata", bus.out_rdata, 32'h0);
    check_eq("rst_out_err",   {31'd0, bus.out_err}, 32'd0);

    // Loads and stores across sizes, lanes and extension modes
    run_op("lb",   2'b00, 2'b01, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_1234, 4'b0000, 32'h0, 32'hFFFF_FF80);
    run_op("lbu",  2'b00, 2'b01, 1'b1, 32'h8000_0003, 32'h0, 32'h80FF_1234, 4'b0000, 32'h0, 32'h0000_0080);
    run_op("lb1",  2'b00, 2'b01, 1'b0, 32'h0000_0001, 32'h0, 32'h0000_7F00, 4'b0000, 32'h0, 32'h0000_007F);
    run_op("sh",   2'b10, 2'b00, 1'b0, 32'h8000_0002, 32'h0000_BEEF, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    run_op("lh",   2'b00, 2'b10, 1'b0, 32'h0000_1002, 32'h0, 32'h8001_7FFF, 4'b0000, 32'h0, 32'hFFFF_8001);
    run_op("lhu",  2'b00, 2'b10, 1'b1, 32'h0000_1000, 32'h0, 32'h1234_F00D, 4'b0000, 32'h0, 32'h0000_F00D);
    run_op("sb",   2'b01, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_56A5, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    run_op("sw",   2'b11, 2'b00, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0);
    run_op("lw",   2'b00, 2'b11, 1'b0, 32'h0000_0204, 32'h0, 32'h89AB_CDEF, 4'b0000, 32'h0, 32'h89AB_CDEF);

    // Ops that never reach the bus
    run_nobus("lw_misalign", 2'b00, 2'b11, 32'h8000_0001, 1'b1);
    run_nobus("sh_misalign", 2'b10, 2'b00, 32'h0000_0003, 1'b1);
    run_nobus("both_en",     2'b11, 2'b11, 32'h0000_0000, 1'b1);
    run_nobus("noop",        2'b00, 2'b00, 32'h0000_0003, 1'b0);

    // Backpressure on both sides
    base_req = n_req_hs;
    base_out = n_out_hs;
    accept(2'b11, 2'b00, 1'b0, 32'h0000_0300, 32'h1122_3344);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
      check_eq("bp_req_addr",  bus.mem_req_addr, 32'h0000_0300);
      check_eq("bp_req_wstrb", {28'd0, bus.mem_req_wstrb}, 32'h0000_000F);
      check_eq("bp_req_wdata", bus.mem_req_wdata, 32'h1122_3344);
      @(negedge clk);
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check_eq("bp_req_dropped", {31'd0, bus.mem_req_valid}, 32'd0);
    bus.mem_rsp_valid = 1'b1;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check_eq("bp_out_rdata", bus.out_rdata, 32'h0);
      check_eq("bp_out_err",   {31'd0, bus.out_err}, 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("bp_idle",      {31'd0, bus.in_ready}, 32'd1);
    check_eq("bp_req_count", n_req_hs - base_req, 32'd1);
    check_eq("bp_out_count", n_out_hs - base_out, 32'd1);

    // Reset while waiting for a response, then a stale response arrives
    accept(2'b00, 2'b11, 1'b0, 32'h0000_0400, 32'h0);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("mid_rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check_eq("mid_rst_out_rdata", bus.out_rdata, 32'h0);
    rst = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'h0000_0055;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("stale_rsp_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("stale_rsp_out_err",   {31'd0, bus.out_err}, 32'd0);
    check_eq("stale_rsp_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    run_op("lw_after_rst", 2'b00, 2'b11, 1'b0, 32'h0000_0400, 32'h0, 32'h600D_F00D, 4'b0000, 32'h0, 32'h600D_F00D);

`ifdef LSU_TIMEOUT_EN
    // Bus never accepts: DONE with error exactly 16 cycles after entering REQ
    begin
      logic early = 1'b0;
      accept(2'b00, 2'b11, 1'b0, 32'h0000_0500, 32'h0);
      for (int i = 1; i < 16; i++) begin
        @(negedge clk);
        if (bus.out_valid) early = 1'b1;
      end
      @(negedge clk);
      check_eq("tmo_not_early", {31'd0, early}, 32'd0);
      check_eq("tmo_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check_eq("tmo_out_err",   {31'd0, bus.out_err}, 32'd1);
      check_eq("tmo_out_rdata", bus.out_rdata, 32'h0);
      check_eq("tmo_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_eq("tmo_idle", {31'd0, bus.in_ready}, 32'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
